// File: rtl/johnson_sequence_tracker_pkg.sv
// Shared definitions for the Johnson counter receive-side tracker and any
// future checkers that consume 4-bit twisted-ring codes.
package johnson_pkg;

    // Tracker acquisition state
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Classification of the index change between two legal samples
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        SKIP = 2'd3
    } move_t;

    // The eight legal codes of a 4-bit Johnson counter, in forward order
    localparam logic [3:0] CODE_0 = 4'b0000;
    localparam logic [3:0] CODE_1 = 4'b0001;
    localparam logic [3:0] CODE_2 = 4'b0011;
    localparam logic [3:0] CODE_3 = 4'b0111;
    localparam logic [3:0] CODE_4 = 4'b1111;
    localparam logic [3:0] CODE_5 = 4'b1110;
    localparam logic [3:0] CODE_6 = 4'b1100;
    localparam logic [3:0] CODE_7 = 4'b1000;

    // A modulo-8 index difference of 1 is a forward step, 7 a reverse step
    function automatic move_t classify(input logic [2:0] delta);
        case (delta)
            3'd0:    return HOLD;
            3'd1:    return FWD;
            3'd7:    return REV;
            default: return SKIP;
        endcase
    endfunction

endpackage

// File: rtl/johnson_sequence_tracker_decode.sv
// Combinational Johnson code decoder: maps a 4-bit code to its ring index
// and flags the eight codes that never appear on a healthy counter.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [3:0] code,
    output logic [2:0] idx,
    output logic       legal
);

    // Table lookup; illegal codes report index 0 with legal deasserted
    always_comb begin
        idx   = 3'd0;
        legal = 1'b1;
        case (code)
            CODE_0:  idx = 3'd0;
            CODE_1:  idx = 3'd1;
            CODE_2:  idx = 3'd2;
            CODE_3:  idx = 3'd3;
            CODE_4:  idx = 3'd4;
            CODE_5:  idx = 3'd5;
            CODE_6:  idx = 3'd6;
            CODE_7:  idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/johnson_sequence_tracker.sv
// Receive-side tracker for 4-bit Johnson counters. Decodes each enabled
// sample, classifies the move relative to the previous legal index, keeps a
// wrapping up/down position, counts errors and locks after a run of
// consecutive same-direction steps.
module johnson_sequence_tracker
    import johnson_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int POS_WIDTH  = 8
)
(
    input  logic                 Clk,
    input  logic                 Clr,
    input  logic                 En,
    input  logic [3:0]           Code,
    output logic [2:0]           Index,
    output logic                 Valid,
    output logic                 Dir,
    output logic                 Step,
    output logic                 Err,
    output logic                 Locked,
    output logic [POS_WIDTH-1:0] Position,
    output logic [7:0]           ErrCount
);

    localparam int               RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [2:0]       ref_idx;

    logic [2:0]       code_idx;
    logic             code_legal;
    logic [2:0]       delta;
    move_t            move;
    logic             move_dir;
    logic [RUN_W-1:0] run_next;
    logic [7:0]       err_count_next;

    johnson_decode u_decode (
        .code  (Code),
        .idx   (code_idx),
        .legal (code_legal)
    );

    // Move classification and next run length; a run continues only while
    // the direction matches the previous legal step, otherwise restarts at 1
    always_comb begin
        delta          = code_idx - ref_idx;
        move           = classify(delta);
        move_dir       = (move == FWD);
        run_next       = RUN_W'(1);
        if (Dir == move_dir) begin
            run_next = (run >= RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
        end
        err_count_next = (ErrCount == 8'hFF) ? 8'hFF : ErrCount + 8'd1;
    end

    // Tracker state machine with all outputs registered; pulses are cleared
    // on every edge and only set by the sample that causes them
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state    <= SEARCH;
            run      <= '0;
            ref_idx  <= 3'd0;
            Index    <= 3'd0;
            Valid    <= 1'b0;
            Dir      <= 1'b1;
            Step     <= 1'b0;
            Err      <= 1'b0;
            Locked   <= 1'b0;
            Position <= '0;
            ErrCount <= 8'd0;
        end else begin
            Step <= 1'b0;
            Err  <= 1'b0;
            if (En) begin
                if (!code_legal) begin
                    Err      <= 1'b1;
                    Valid    <= 1'b0;
                    ErrCount <= err_count_next;
                    state    <= SEARCH;
                    Locked   <= 1'b0;
                    run      <= '0;
                end else begin
                    Valid   <= 1'b1;
                    Index   <= code_idx;
                    ref_idx <= code_idx;
                    if (state == SEARCH) begin
                        state <= TRACK;
                        run   <= '0;
                    end else begin
                        case (move)
                            HOLD: begin
                            end
                            FWD, REV: begin
                                Step     <= 1'b1;
                                Position <= move_dir ? Position + POS_WIDTH'(1)
                                                     : Position - POS_WIDTH'(1);
                                run      <= run_next;
                                Dir      <= move_dir;
                                if (state == TRACK && run_next == RUN_MAX) begin
                                    state  <= LOCKED;
                                    Locked <= 1'b1;
                                end
                            end
                            default: begin
                                Err      <= 1'b1;
                                ErrCount <= err_count_next;
                                run      <= '0;
                                state    <= TRACK;
                                Locked   <= 1'b0;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/johnson_sequence_tracker.md
Name: johnson_sequence_tracker

Overview:
- Receive-side companion to the team's 4-bit Johnson (twisted-ring) counters.
- Samples a 4-bit Johnson code, decodes it to a 3-bit index, and classifies each move as forward, reverse, hold, skip or illegal.
- Maintains a wrapping up/down position count and a lock flag.
- Checks or consumes counter outputs generated in either direction: 0->1->3->7->15->14->12->8->0 or its reverse.

Parameters:
- LOCK_COUNT, 4, consecutive same-direction legal steps required to assert Locked (legal range >=1).
- POS_WIDTH, 8, width of the Position counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous, active-low reset.
- En  input  1  sample enable; Code is evaluated only when En=1.
- Code  input  4  Johnson code under observation.
- Index  output  3  decoded index of the last sampled legal code.
- Valid  output  1  last sampled code was legal.
- Dir  output  1  direction of the last legal step: 1=forward, 0=reverse.
- Step  output  1  one-cycle pulse when a legal single step is accepted.
- Err  output  1  one-cycle pulse on an illegal code or a skip.
- Locked  output  1  tracker is locked.
- Position  output  POS_WIDTH  up/down step count, wraps modulo 2^POS_WIDTH.
- ErrCount  output  8  saturating error count.

Behaviour:
- Reset (Clr=0, asynchronous): state=SEARCH, Index=0, Valid=0, Dir=1, Step=0, Err=0, Locked=0, Position=0, ErrCount=0, run=0, ref=0.
- Decode map: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7. The other 8 codes are illegal.
- Timing: all outputs are registered. An En=1 sample at edge k is reflected on the outputs after edge k, so latency is 1 cycle.
- En=0: every register holds, except Step and Err, which are forced to 0.
- On an illegal sample (any state):
  - Err=1, Valid=0, ErrCount+1 (saturates at 255).
  - Next state=SEARCH, Locked=0, run=0.
  - Index, Position and Dir hold.
- On a legal sample: Valid=1, Index=decoded value. Then compute delta=(idx-ref) mod 8 and update ref=idx.
- SEARCH state: a legal sample goes to TRACK with run=0. There is no Step and no Position change.
- TRACK and LOCKED states, by delta:
  - delta=0 (hold): no change, Step=0.
  - delta=1 (forward step): Step=1, Position+1. If Dir was already 1, run+1 (saturating at LOCK_COUNT); otherwise run=1. Then Dir=1.
  - delta=7 (reverse step): Step=1, Position-1. Run updates by the same rule with Dir=0. Then Dir=0.
  - delta 2..6 (skip): Err=1, ErrCount+1 (saturating), Step=0, Position holds, run=0. Next state=TRACK, Locked=0.
- TRACK -> LOCKED when the updated run reaches LOCK_COUNT. Locked=1 in the same output update as the qualifying Step.
- LOCKED: a direction reversal keeps the block LOCKED (Dir updates, run=1). Only a skip or an illegal code unlocks it.
- Position wraps both ways: from 2^POS_WIDTH-1, +1 gives 0; from 0, -1 gives all ones.
- A reset mid-operation overrides everything immediately. The first legal sample after reset is treated as a SEARCH acquisition.

Decomposition:
- Package johnson_pkg:
  - state encoding constants SEARCH/TRACK/LOCKED;
  - the eight legal code constants;
  - delta classification constants HOLD/FWD/REV/SKIP.
- Sub-module johnson_decode: combinational, Code[3:0] -> idx[2:0] plus legal flag. It is also reusable by future counter checkers.
- run counter width = clog2(LOCK_COUNT+1).

Test Plan:
- Reset mid-operation: reach Locked with Position=5, pulse Clr low between edges -> all outputs zero immediately, Dir=1; next legal Code gives Step=0.
- Forward run: En=1, Code=0,1,3,7,15,14,12,8,0 -> Index 0..7,0; Step=1 from the 2nd sample on; Locked=1 with the 4th Step; Position=8; Dir=1.
- Reverse run after reset: Code=0,8,12,14,15 -> Index 0,7,6,5,4; Dir=0; Position=0xFC; Locked=1 on the 4th Step.
- Illegal code while locked: Code=0101 -> Err pulse, Valid=0, Locked=0, ErrCount=1, Position and Index held. Next Code=0011 -> no Step; Code=0111 -> Step=1, Position+1.
- Skip and hold: Code 0001,0001,0111 -> no pulse on the hold; on the skip Err=1, Step=0, Position unchanged, Locked=0. Insert En=0 cycles with Code toggling -> no output changes.
- Saturation: feed 260 illegal codes -> ErrCount=255 and holds; Err pulses on every sample.
